uart_rx_os: RTL and testbench

- Oversampling UART receiver. Sits directly upstream of the seven-segment digit counter and feeds it a byte plus a one-cycle `received` strobe.
- Adds synchronous reset, input synchronisation, majority-vote sampling, false-start rejection and framing-error reporting.
- 8N1 by default, LSB first.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_baud_tick.sv | 37 +++
 rtl/uart_rx_os.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_os.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the oversampling UART receiver.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

  // Rounded clocks-per-sample-tick, never below 1.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud,
                                           input int unsigned os);
    int unsigned den;
    int unsigned div;
    den = baud * os;
    div = (clk_hz + den / 2) / den;
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: one-clk tick every Div clocks, restartable to phase zero.
module uart_baud_tick #(
  parameter int unsigned Div = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic restart_i,
  output logic tick_o
);

  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling 8N1 UART receiver with majority vote, false-start and framing checks.
// Define UART_RX_PARITY_EN to add a parity bit check and the parity_err output.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 12000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter int unsigned PARITY_ODD = 0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rxbyte,
  output logic       received,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int unsigned Div     = calc_div(CLK_HZ, BAUD, OVERSAMPLE);
  localparam int unsigned TickW   = $clog2(OVERSAMPLE);
  localparam int unsigned BitW    = $clog2(DATA_BITS);
  localparam logic [TickW-1:0] StartS0 = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] StartS1 = TickW'(OVERSAMPLE / 2);
  localparam logic [TickW-1:0] StartEv = TickW'(OVERSAMPLE / 2 + 1);
  localparam logic [TickW-1:0] BitS0   = TickW'(OVERSAMPLE - 3);
  localparam logic [TickW-1:0] BitS1   = TickW'(OVERSAMPLE - 2);
  localparam logic [TickW-1:0] BitEv   = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  LastBit = BitW'(DATA_BITS - 1);

  uart_state_e      state_q, state_d;
  logic [1:0]       sync_q, sync_d;
  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic [1:0]       vote_q, vote_d;
  logic [7:0]       rxbyte_q, rxbyte_d;
  logic             received_q, received_d;
  logic             frame_err_q, frame_err_d;
  logic             busy_q;
  logic             rx_s, tick, restart, maj, at_eval;
  logic [TickW-1:0] win0, win1, win_ev;
`ifdef UART_RX_PARITY_EN
  logic             par_bad_q, par_bad_d;
  logic             parity_err_q, parity_err_d;
  localparam logic  ParOdd = (PARITY_ODD != 0);
`endif

  uart_baud_tick #(
    .Div(Div)
  ) u_baud_tick (
    .clk_i    (clk),
    .rst_i    (rst),
    .restart_i(restart),
    .tick_o   (tick)
  );

  assign sync_d = {sync_q[0], rx};
  assign rx_s   = sync_q[1];
  assign maj    = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);

  // START samples around the half-bit; later bits are counted from that mid-bit point.
  always_comb begin
    win0   = (state_q == StStart) ? StartS0 : BitS0;
    win1   = (state_q == StStart) ? StartS1 : BitS1;
    win_ev = (state_q == StStart) ? StartEv : BitEv;
  end

  assign at_eval = tick && (tick_cnt_q == win_ev);

  always_comb begin
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    vote_d      = vote_q;
    rxbyte_d    = rxbyte_q;
    received_d  = 1'b0;
    frame_err_d = 1'b0;
    restart     = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_d    = par_bad_q;
    parity_err_d = 1'b0;
`endif
    if (tick && state_q != StIdle && state_q != StBreak) begin
      tick_cnt_d = (tick_cnt_q == BitEv) ? '0 : tick_cnt_q + TickW'(1);
      if (tick_cnt_q == win0) vote_d[0] = rx_s;
      if (tick_cnt_q == win1) vote_d[1] = rx_s;
    end
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d    = StStart;
          tick_cnt_d = '0;
          bit_cnt_d  = '0;
          restart    = 1'b1;
        end
      end
      StStart: begin
        if (at_eval) begin
          if (maj) begin
            state_d = StIdle;
          end else begin
            state_d    = StData;
            tick_cnt_d = '0;
          end
        end
      end
      StData: begin
        if (at_eval) begin
          shreg_d   = {maj, shreg_q[7:1]};
          bit_cnt_d = bit_cnt_q + BitW'(1);
          if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (at_eval) begin
          par_bad_d = maj ^ (^shreg_q) ^ ParOdd;
          state_d   = StStop;
        end
      end
`endif
      StStop: begin
        if (at_eval) begin
          if (maj) begin
            state_d = StIdle;
`ifdef UART_RX_PARITY_EN
            if (par_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              rxbyte_d   = shreg_q;
              received_d = 1'b1;
            end
`else
            rxbyte_d   = shreg_q;
            received_d = 1'b1;
`endif
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end
      end
      StBreak: begin
        if (rx_s) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      sync_q      <= 2'b11;
      tick_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      vote_q      <= '0;
      rxbyte_q    <= '0;
      received_q  <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync_q      <= sync_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      vote_q      <= vote_d;
      rxbyte_q    <= rxbyte_d;
      received_q  <= received_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != StIdle);
`ifdef UART_RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rxbyte    = rxbyte_q;
  assign received  = received_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os at 16 clk per bit (DIV=1); honours UART_RX_PARITY_EN.
`timescale 1ns/1ps
module tb_uart_rx_os;

  localparam int unsigned ClkHz  = 1600000;
  localparam int unsigned Baud   = 100000;
  localparam int unsigned Os     = 16;
  localparam int unsigned BitClk = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rxbyte;
  logic       received, frame_err, busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;
  int rx_cnt = 0, fe_cnt = 0, pe_cnt = 0, both_cnt = 0;
  longint cyc = 0, prev_rx_cyc = 0, last_rx_cyc = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_byte;
  logic [7:0] last_good = 8'h00;

  uart_rx_os #(
    .CLK_HZ    (ClkHz),
    .BAUD      (Baud),
`ifdef UART_RX_PARITY_EN
    .PARITY_ODD(0),
`endif
    .OVERSAMPLE(Os)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .rxbyte   (rxbyte),
    .received (received),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every received pulse must match the oldest expected byte.
  always @(negedge clk) begin
    if (received) begin
      rx_cnt++;
      prev_rx_cyc = last_rx_cyc;
      last_rx_cyc = cyc;
      tests_run++;
      if (exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL sb_unexpected: received with rxbyte=%02h, nothing expected", rxbyte);
      end else begin
        exp_byte = exp_q.pop_front();
        if (rxbyte !== exp_byte) begin
          tests_failed++;
          $display("FAIL sb_byte: got %02h, expected %02h", rxbyte, exp_byte);
        end
      end
    end
    if (frame_err) fe_cnt++;
    if (received && frame_err) both_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (BitClk) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_ok);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop_ok);
  endtask

  task automatic expect_byte(input logic [7:0] d);
    exp_q.push_back(d);
    last_good = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    tests_run += 4;
    if (rxbyte !== 8'h00) begin tests_failed++; $display("FAIL reset_rxbyte: got %02h, expected 00", rxbyte); end
    if (received !== 1'b0) begin tests_failed++; $display("FAIL reset_received: got %b, expected 0", received); end
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    rst = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    int rx0, fe0;
    rx0 = rx_cnt; fe0 = fe_cnt;
    expect_byte(8'h55);
    send_frame(8'h55, 1'b1);
    repeat (40) @(negedge clk);
    tests_run += 4;
    if (rx_cnt - rx0 != 1) begin tests_failed++; $display("FAIL single_count: got %0d pulses, expected 1", rx_cnt - rx0); end
    if (rxbyte !== 8'h55) begin tests_failed++; $display("FAIL single_rxbyte: got %02h, expected 55", rxbyte); end
    if (fe_cnt != fe0) begin tests_failed++; $display("FAIL single_frame_err: got %0d pulses, expected 0", fe_cnt - fe0); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_back_to_back();
    int rx0;
    rx0 = rx_cnt;
    expect_byte(8'hA3);
    expect_byte(8'h0F);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    repeat (40) @(negedge clk);
    tests_run += 3;
    if (rx_cnt - rx0 != 2) begin tests_failed++; $display("FAIL b2b_count: got %0d pulses, expected 2", rx_cnt - rx0); end
    if (last_rx_cyc - prev_rx_cyc != 160) begin
      tests_failed++; $display("FAIL b2b_gap: got %0d clk, expected 160", last_rx_cyc - prev_rx_cyc);
    end
    if (rxbyte !== 8'h0F) begin tests_failed++; $display("FAIL b2b_rxbyte: got %02h, expected 0F", rxbyte); end
  endtask

  task automatic test_glitch();
    int rx0, fe0, n;
    logic busy_at_release;
    rx0 = rx_cnt; fe0 = fe_cnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    busy_at_release = busy;
    n = 0;
    while (busy !== 1'b0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    tests_run += 2;
    if (busy_at_release !== 1'b1) begin tests_failed++; $display("FAIL glitch_busy_seen: got %b, expected 1", busy_at_release); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL glitch_busy_timeout: busy=%b after %0d clk, expected 0", busy, n); end
    repeat (30) @(negedge clk);
    tests_run += 2;
    if (rx_cnt != rx0) begin tests_failed++; $display("FAIL glitch_received: got %0d pulses, expected 0", rx_cnt - rx0); end
    if (fe_cnt != fe0) begin tests_failed++; $display("FAIL glitch_frame_err: got %0d pulses, expected 0", fe_cnt - fe0); end
  endtask

  task automatic test_frame_err();
    int rx0, fe0;
    rx0 = rx_cnt; fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    tests_run += 3;
    if (fe_cnt - fe0 != 1) begin tests_failed++; $display("FAIL ferr_count: got %0d pulses, expected 1", fe_cnt - fe0); end
    if (rx_cnt != rx0) begin tests_failed++; $display("FAIL ferr_received: got %0d pulses, expected 0", rx_cnt - rx0); end
    if (rxbyte !== last_good) begin tests_failed++; $display("FAIL ferr_rxbyte: got %02h, expected %02h", rxbyte, last_good); end
    fe0 = fe_cnt;
    send_frame(8'h3C, 1'b0);
    repeat (50 * BitClk) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    tests_run += 3;
    if (fe_cnt - fe0 != 1) begin tests_failed++; $display("FAIL break_count: got %0d pulses, expected 1", fe_cnt - fe0); end
    if (rx_cnt != rx0) begin tests_failed++; $display("FAIL break_received: got %0d pulses, expected 0", rx_cnt - rx0); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL break_busy: got %b, expected 0", busy); end
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    int rx0;
    d   = 8'h81;
    rx0 = rx_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (8) @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    @(posedge clk);
    #1;
    tests_run += 4;
    if (rxbyte !== 8'h00) begin tests_failed++; $display("FAIL abort_rxbyte: got %02h, expected 00", rxbyte); end
    if (received !== 1'b0) begin tests_failed++; $display("FAIL abort_received: got %b, expected 0", received); end
    if (frame_err !== 1'b0) begin tests_failed++; $display("FAIL abort_frame_err: got %b, expected 0", frame_err); end
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL abort_busy: got %b, expected 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    last_good = 8'h00;
    repeat (40) @(negedge clk);
    expect_byte(8'h7E);
    send_frame(8'h7E, 1'b1);
    repeat (40) @(negedge clk);
    tests_run += 2;
    if (rx_cnt - rx0 != 1) begin tests_failed++; $display("FAIL abort_count: got %0d pulses, expected 1", rx_cnt - rx0); end
    if (rxbyte !== 8'h7E) begin tests_failed++; $display("FAIL abort_next_rxbyte: got %02h, expected 7E", rxbyte); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic send_frame_par(input logic [7:0] d, input logic par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(par);
    send_bit(1'b1);
  endtask

  task automatic test_parity();
    int rx0, pe0;
    rx0 = rx_cnt; pe0 = pe_cnt;
    expect_byte(8'h07);
    send_frame_par(8'h07, 1'b1);
    repeat (40) @(negedge clk);
    tests_run += 3;
    if (rx_cnt - rx0 != 1) begin tests_failed++; $display("FAIL par_good_count: got %0d pulses, expected 1", rx_cnt - rx0); end
    if (pe_cnt != pe0) begin tests_failed++; $display("FAIL par_good_perr: got %0d pulses, expected 0", pe_cnt - pe0); end
    if (rxbyte !== 8'h07) begin tests_failed++; $display("FAIL par_good_rxbyte: got %02h, expected 07", rxbyte); end
    rx0 = rx_cnt; pe0 = pe_cnt;
    send_frame_par(8'h07, 1'b0);
    repeat (40) @(negedge clk);
    tests_run += 2;
    if (pe_cnt - pe0 != 1) begin tests_failed++; $display("FAIL par_bad_perr: got %0d pulses, expected 1", pe_cnt - pe0); end
    if (rx_cnt != rx0) begin tests_failed++; $display("FAIL par_bad_received: got %0d pulses, expected 0", rx_cnt - rx0); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_frame_err();
    test_reset_abort();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    tests_run += 2;
    if (exp_q.size() != 0) begin tests_failed++; $display("FAIL sb_leftover: got %0d pending bytes, expected 0", exp_q.size()); end
    if (both_cnt != 0) begin tests_failed++; $display("FAIL overlap: got %0d clk with received and frame_err, expected 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
